// File: rtl/mem_stage.sv
// mem_stage: memory / writeback-prep stage that sits directly after the ALU.
//
// Takes one instruction per ex_valid/ex_ready handshake. Non-memory ops are
// turned into a writeback beat on the next cycle. Loads and stores are issued
// on the dmem req/gnt/rvalid interface. Load data is lane-shifted and sign- or
// zero-extended. Misaligned or illegal memory ops raise a one-cycle exception
// pulse instead of touching memory. Exactly one registered wb_valid pulse is
// produced per accepted instruction.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   ex_valid / ex_ready   upstream handshake (ex_ready is high only in IDLE)
//   alu_result            ALU result; effective address for memory ops
//   rs2_data              store data
//   mem_read, mem_write   load / store (both set = illegal)
//   funct3                access size and sign (B, H, W, BU, HU)
//   reg_write, rd_addr    destination register control
//   dmem_req/we/addr/be/wdata   data-memory request, held until dmem_gnt
//   dmem_gnt              request accepted this cycle
//   dmem_rvalid, dmem_rdata     load response (full word)
//   wb_valid/we/rd/data   writeback beat (wb_valid is a one-cycle pulse)
//   misaligned_exc        one-cycle pulse, coincident with wb_valid
//   exc_addr              faulting address, held until the next exception
module mem_stage #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] rs2_data,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [2:0]    funct3,
    input  logic          reg_write,
    input  logic [4:0]    rd_addr,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [3:0]    dmem_be,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_gnt,
    input  logic          dmem_rvalid,
    input  logic [DW-1:0] dmem_rdata,
    output logic          wb_valid,
    output logic          wb_we,
    output logic [4:0]    wb_rd,
    output logic [DW-1:0] wb_data,
    output logic          misaligned_exc,
    output logic [DW-1:0] exc_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state, state_next;

    // Request context latched at accept; used when the response returns.
    logic [1:0]    off_p1;
    logic [2:0]    funct3_p1;
    logic          rw_p1;
    logic [4:0]    rd_p1;
    logic [DW-1:0] addr_p1;

    logic accept;
    logic mem_op;
    logic bad_op;

    // Illegal combinations: read&write, unknown funct3, unsigned sizes on a
    // store, and sizes that straddle their natural alignment.
    function automatic logic is_bad(input logic rd, input logic wr,
                                    input logic [2:0] f3, input logic [1:0] off);
        logic r;
        r = 1'b1;
        if (!(rd && wr)) begin
            case (f3)
                3'b000:  r = 1'b0;
                3'b001:  r = off[0];
                3'b010:  r = (off != 2'b00);
                3'b100:  r = wr;
                3'b101:  r = wr | off[0];
                default: r = 1'b1;
            endcase
        end
        return r;
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [DW-1:0] lane_wdata(input logic [2:0] f3, input logic [DW-1:0] d);
        logic [DW-1:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Shift the addressed lane down to bit 0, then extend by funct3.
    function automatic logic [DW-1:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [DW-1:0] rdata);
        logic [DW-1:0]        sh;
        logic signed [7:0]    b;
        logic signed [15:0]   h;
        logic [DW-1:0]        r;
        sh = rdata >> {off, 3'b000};
        b  = $signed(sh[7:0]);
        h  = $signed(sh[15:0]);
        case (f3)
            3'b000:  r = {{(DW-8){b[7]}}, b};
            3'b001:  r = {{(DW-16){h[15]}}, h};
            3'b100:  r = {{(DW-8){1'b0}}, sh[7:0]};
            3'b101:  r = {{(DW-16){1'b0}}, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid & ex_ready;
    assign mem_op   = mem_read | mem_write;
    assign bad_op   = is_bad(mem_read, mem_write, funct3, alu_result[1:0]);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && mem_op && !bad_op) state_next = REQ;
            REQ:     if (dmem_gnt) state_next = dmem_we ? IDLE : WAIT;
            WAIT:    if (dmem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---- stage p1: request issue and writeback beat ----
    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_be        <= '0;
            dmem_wdata     <= '0;
            wb_valid       <= 1'b0;
            wb_we          <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            misaligned_exc <= 1'b0;
            exc_addr       <= '0;
            off_p1         <= '0;
            funct3_p1      <= '0;
            rw_p1          <= 1'b0;
            rd_p1          <= '0;
            addr_p1        <= '0;
        end else begin
            wb_valid       <= 1'b0;
            misaligned_exc <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!mem_op) begin
                            wb_valid <= 1'b1;
                            wb_we    <= reg_write;
                            wb_rd    <= rd_addr;
                            wb_data  <= alu_result;
                        end else if (bad_op) begin
                            wb_valid       <= 1'b1;
                            wb_we          <= 1'b0;
                            wb_rd          <= rd_addr;
                            wb_data        <= alu_result;
                            misaligned_exc <= 1'b1;
                            exc_addr       <= alu_result;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= {alu_result[DW-1:2], 2'b00};
                            dmem_be    <= lane_be(funct3, alu_result[1:0]);
                            dmem_wdata <= lane_wdata(funct3, rs2_data);
                            off_p1     <= alu_result[1:0];
                            funct3_p1  <= funct3;
                            rw_p1      <= reg_write;
                            rd_p1      <= rd_addr;
                            addr_p1    <= alu_result;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        if (dmem_we) begin
                            wb_valid <= 1'b1;
                            wb_we    <= 1'b0;
                            wb_rd    <= rd_p1;
                            wb_data  <= addr_p1;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        wb_valid <= 1'b1;
                        wb_we    <= rw_p1;
                        wb_rd    <= rd_p1;
                        wb_data  <= load_fmt(funct3_p1, off_p1, dmem_rdata);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned_exc;
    logic [31:0] exc_addr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_stage #(.DW(32)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_result(alu_result), .rs2_data(rs2_data),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .reg_write(reg_write), .rd_addr(rd_addr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .misaligned_exc(misaligned_exc), .exc_addr(exc_addr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic rd,
                         input logic wr, input logic [2:0] f3, input logic rw, input logic [4:0] rdst);
        ex_valid   = 1'b1;
        alu_result = a;
        rs2_data   = d;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        reg_write  = rw;
        rd_addr    = rdst;
    endtask

    task automatic test_reset();
        reset = 1'b1; ex_valid = 1'b0; alu_result = '0; rs2_data = '0;
        mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000; reg_write = 1'b0;
        rd_addr = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", ex_ready); end
        vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b exp 0", dmem_req); end
        vectors++; if (dmem_be !== 4'b0000) begin miscompares++; $display("FAIL reset_be got %b exp 0000", dmem_be); end
        vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wbv got %b exp 0", wb_valid); end
        vectors++; if (wb_data !== 32'h0) begin miscompares++; $display("FAIL reset_wbdata got %h exp 0", wb_data); end
        vectors++; if (misaligned_exc !== 1'b0 || exc_addr !== 32'h0) begin miscompares++;
            $display("FAIL reset_exc got %b/%h exp 0/0", misaligned_exc, exc_addr); end
    endtask

    task automatic test_alu();
        issue(32'h12345678, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd5);
        tick();
        ex_valid = 1'b0;
        vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL alu_wbv got %b exp 1", wb_valid); end
        vectors++; if (wb_data !== 32'h12345678) begin miscompares++; $display("FAIL alu_data got %h exp 12345678", wb_data); end
        vectors++; if (wb_rd !== 5'd5 || wb_we !== 1'b1) begin miscompares++;
            $display("FAIL alu_rd_we got %0d/%b exp 5/1", wb_rd, wb_we); end
        tick();
        vectors++; if (wb_valid !== 1'b0 || wb_data !== 32'h12345678) begin miscompares++;
            $display("FAIL alu_hold got %b/%h exp 0/12345678", wb_valid, wb_data); end
    endtask

    task automatic test_back_to_back();
        issue(32'hAAAA0001, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd1);
        tick();
        vectors++; if (wb_valid !== 1'b1 || wb_data !== 32'hAAAA0001 || ex_ready !== 1'b1) begin miscompares++;
            $display("FAIL b2b_first got %b/%h/%b exp 1/aaaa0001/1", wb_valid, wb_data, ex_ready); end
        issue(32'hBBBB0002, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd2);
        tick();
        ex_valid = 1'b0;
        vectors++; if (wb_valid !== 1'b1 || wb_data !== 32'hBBBB0002 || wb_rd !== 5'd2 || wb_we !== 1'b0) begin
            miscompares++; $display("FAIL b2b_second got %b/%h/%0d/%b exp 1/bbbb0002/2/0", wb_valid, wb_data, wb_rd, wb_we); end
        tick();
    endtask

    // Load with immediate gnt and rvalid two cycles after gnt.
    task automatic test_load(input string nm, input logic [31:0] a, input logic [2:0] f3,
                             input logic [31:0] rdata, input logic [3:0] exp_be, input logic [31:0] exp_data);
        issue(a, 32'h0, 1'b1, 1'b0, f3, 1'b1, 5'd7);
        tick();
        ex_valid = 1'b0;
        vectors++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || ex_ready !== 1'b0) begin miscompares++;
            $display("FAIL %s_req got req=%b we=%b rdy=%b exp 1/0/0", nm, dmem_req, dmem_we, ex_ready); end
        vectors++; if (dmem_addr !== {a[31:2], 2'b00} || dmem_be !== exp_be) begin miscompares++;
            $display("FAIL %s_addr_be got %h/%b exp %h/%b", nm, dmem_addr, dmem_be, {a[31:2], 2'b00}, exp_be); end
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        vectors++; if (dmem_req !== 1'b0 || wb_valid !== 1'b0) begin miscompares++;
            $display("FAIL %s_wait got req=%b wbv=%b exp 0/0", nm, dmem_req, wb_valid); end
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        tick();
        dmem_rvalid = 1'b0;
        vectors++; if (wb_valid !== 1'b1 || wb_data !== exp_data) begin miscompares++;
            $display("FAIL %s_data got %b/%h exp 1/%h", nm, wb_valid, wb_data, exp_data); end
        vectors++; if (wb_we !== 1'b1 || wb_rd !== 5'd7 || ex_ready !== 1'b1) begin miscompares++;
            $display("FAIL %s_wb got we=%b rd=%0d rdy=%b exp 1/7/1", nm, wb_we, wb_rd, ex_ready); end
        tick();
    endtask

    task automatic test_store(input string nm, input logic [31:0] a, input logic [2:0] f3,
                              input logic [31:0] d, input logic [3:0] exp_be, input logic [31:0] exp_wd);
        issue(a, d, 1'b0, 1'b1, f3, 1'b1, 5'd9);
        tick();
        ex_valid = 1'b0;
        vectors++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== {a[31:2], 2'b00}) begin miscompares++;
            $display("FAIL %s_req got %b/%b/%h exp 1/1/%h", nm, dmem_req, dmem_we, dmem_addr, {a[31:2], 2'b00}); end
        vectors++; if (dmem_be !== exp_be || dmem_wdata !== exp_wd) begin miscompares++;
            $display("FAIL %s_lanes got %b/%h exp %b/%h", nm, dmem_be, dmem_wdata, exp_be, exp_wd); end
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        vectors++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || dmem_req !== 1'b0 || ex_ready !== 1'b1) begin miscompares++;
            $display("FAIL %s_done got wbv=%b we=%b req=%b rdy=%b exp 1/0/0/1", nm, wb_valid, wb_we, dmem_req, ex_ready); end
        tick();
    endtask

    task automatic test_gnt_delay();
        int pulses;
        pulses = 0;
        issue(32'h00004000, 32'hCAFEF00D, 1'b0, 1'b1, 3'b010, 1'b0, 5'd3);
        tick();
        // Keep a different op on the upstream bus; it must be ignored while busy.
        issue(32'hDEAD0000, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd4);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (dmem_req !== 1'b1 || dmem_addr !== 32'h00004000 || dmem_be !== 4'b1111 ||
                dmem_wdata !== 32'hCAFEF00D || ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL gnt_delay_hold[%0d] got req=%b addr=%h be=%b wd=%h rdy=%b wbv=%b exp 1/00004000/1111/cafef00d/0/0",
                         i, dmem_req, dmem_addr, dmem_be, dmem_wdata, ex_ready, wb_valid);
            end
            if (i == 3) dmem_gnt = 1'b1;
            tick();
        end
        dmem_gnt = 1'b0;
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (wb_valid === 1'b1) pulses++;
            tick();
        end
        vectors++; if (pulses != 1) begin miscompares++; $display("FAIL gnt_delay_pulses got %0d exp 1", pulses); end
        vectors++; if (wb_data === 32'hDEAD0000) begin miscompares++;
            $display("FAIL gnt_delay_ignore got %h exp not dead0000", wb_data); end
    endtask

    task automatic test_misaligned(input string nm, input logic [31:0] a, input logic rd,
                                   input logic wr, input logic [2:0] f3);
        issue(a, 32'h0, rd, wr, f3, 1'b1, 5'd11);
        tick();
        ex_valid = 1'b0;
        vectors++; if (misaligned_exc !== 1'b1 || exc_addr !== a) begin miscompares++;
            $display("FAIL %s_exc got %b/%h exp 1/%h", nm, misaligned_exc, exc_addr, a); end
        vectors++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || dmem_req !== 1'b0 || ex_ready !== 1'b1) begin miscompares++;
            $display("FAIL %s_wb got wbv=%b we=%b req=%b rdy=%b exp 1/0/0/1", nm, wb_valid, wb_we, dmem_req, ex_ready); end
        tick();
        vectors++; if (misaligned_exc !== 1'b0 || exc_addr !== a || dmem_req !== 1'b0) begin miscompares++;
            $display("FAIL %s_after got exc=%b addr=%h req=%b exp 0/%h/0", nm, misaligned_exc, exc_addr, dmem_req, a); end
    endtask

    task automatic test_reset_in_wait();
        issue(32'h00006000, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd12);
        tick();
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || ex_ready !== 1'b1) begin miscompares++;
            $display("FAIL rst_wait_state got req=%b wbv=%b rdy=%b exp 0/0/1", dmem_req, wb_valid, ex_ready); end
        dmem_rvalid = 1'b1; dmem_rdata = 32'h55555555;
        tick();
        dmem_rvalid = 1'b0;
        vectors++; if (wb_valid !== 1'b0 || wb_data !== 32'h0) begin miscompares++;
            $display("FAIL rst_wait_rvalid got %b/%h exp 0/00000000", wb_valid, wb_data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load("lb",  32'h00001003, 3'b000, 32'h80000000, 4'b1000, 32'hFFFFFF80);
        test_load("lbu", 32'h00001003, 3'b100, 32'h80000000, 4'b1000, 32'h00000080);
        test_load("lh",  32'h00001002, 3'b001, 32'h80010000, 4'b1100, 32'hFFFF8001);
        test_load("lhu", 32'h00001002, 3'b101, 32'h80010000, 4'b1100, 32'h00008001);
        test_load("lw",  32'h00001000, 3'b010, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        test_store("sh", 32'h00002002, 3'b001, 32'hABCD1234, 4'b1100, 32'h12341234);
        test_store("sb", 32'h00002001, 3'b000, 32'hABCD1234, 4'b0010, 32'h34343434);
        test_gnt_delay();
        test_misaligned("lw_mis", 32'h00003001, 1'b1, 1'b0, 3'b010);
        test_misaligned("lh_mis", 32'h00003003, 1'b1, 1'b0, 3'b001);
        test_misaligned("rdwr",   32'h00005000, 1'b1, 1'b1, 3'b010);
        test_misaligned("sbu",    32'h00005004, 1'b0, 1'b1, 3'b100);
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
